// File: rtl/pc_gen_pkg.sv
// pc_pkg: shared definitions for the fetch-stage program-counter generator.
//   - state_t      : fetch FSM states (S_OFF while in reset, S_RUN otherwise)
//   - STALL_BIT    : index of the stall-vector bit that stops fetch
//   - STALL_STOP   : value of that bit that means "stop"
//   - BRANCH_TAKEN : value of i_branch_vld that requests a redirect
//   - align_mask() : mask of the byte-offset bits inside one instruction
package pc_pkg;

  typedef enum logic {
    S_OFF = 1'b0,
    S_RUN = 1'b1
  } state_t;

  localparam int   STALL_BIT    = 0;
  localparam logic STALL_STOP   = 1'b1;
  localparam logic BRANCH_TAKEN = 1'b1;

  // Widest PC the helper supports; callers size-cast the result down.
  localparam int PC_MAX_W = 64;

  // For a power-of-two instruction size the offset bits are exactly
  // inst_bytes-1 (e.g. 4 -> 2'b11). inst_bytes=1 gives an all-zero mask,
  // so nothing can ever be misaligned.
  function automatic logic [PC_MAX_W-1:0] align_mask(input int unsigned inst_bytes);
    logic [PC_MAX_W-1:0] bytes_w;
    bytes_w = PC_MAX_W'(inst_bytes);
    return bytes_w - PC_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: instruction-memory request channel of the fetch stage.
//   o_ce       fetch enable (driven by pc_gen)
//   o_req_vld  request valid (driven by pc_gen)
//   o_pc       fetch address (driven by pc_gen)
//   i_req_rdy  memory accepts the request this cycle (driven by memory)
// master = pc_gen side, slave = instruction-memory side.
interface pc_gen_if #(
  parameter int N_ADDR = 32
) ();

  logic              o_ce;
  logic              o_req_vld;
  logic [N_ADDR-1:0] o_pc;
  logic              i_req_rdy;

  modport master (
    output o_ce,
    output o_req_vld,
    output o_pc,
    input  i_req_rdy
  );

  modport slave (
    input  o_ce,
    input  o_req_vld,
    input  o_pc,
    output i_req_rdy
  );

endinterface

// File: rtl/pc_gen_redirect_buf.sv
// pc_redirect_buf: one-entry buffer for a branch that arrived while fetch
// could not advance.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   capture         load capture_addr and mark valid (newer overwrites older)
//   clear           drop the entry (flush, or a newer branch taken directly)
//   consume         drop the entry because it is being applied to the PC
//   capture_addr    raw branch target to remember
//   pend_vld        an entry is held
//   pend_addr       the held target, unmodified (alignment is checked later)
module pc_redirect_buf #(
  parameter int N_ADDR = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              capture,
  input  logic              clear,
  input  logic              consume,
  input  logic [N_ADDR-1:0] capture_addr,
  output logic              pend_vld,
  output logic [N_ADDR-1:0] pend_addr
);

  logic              vld_reg;
  logic              vld_next;
  logic [N_ADDR-1:0] addr_reg;
  logic [N_ADDR-1:0] addr_next;

  // Dropping the entry wins over a capture; the top never asks for both in
  // one cycle, but this ordering keeps a flush authoritative regardless.
  always_comb begin
    vld_next  = vld_reg;
    addr_next = addr_reg;
    if (clear || consume) begin
      vld_next = 1'b0;
    end else if (capture) begin
      vld_next  = 1'b1;
      addr_next = capture_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_reg  <= 1'b0;
      addr_reg <= '0;
    end else begin
      vld_reg  <= vld_next;
      addr_reg <= addr_next;
    end
  end

  assign pend_vld  = vld_reg;
  assign pend_addr = addr_reg;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
// Issues instruction-memory requests over a valid/ready handshake, applies
// flush and branch redirects with a fixed priority, buffers a branch that
// arrives while fetch is held, and reports misaligned redirect targets.
//
// Parameters
//   N_ADDR      PC width in bits
//   RESET_VEC   first fetch address after reset
//   INST_BYTES  instruction size in bytes (power of two, >= 1)
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_stall          stall vector; only bit STALL_BIT stops fetch
//   i_flush          exception flush (highest priority), target i_new_pc
//   i_branch_vld     single-cycle redirect request, target i_branch_addr
//   fetch            memory request channel (o_ce, o_req_vld, o_pc, i_req_rdy)
//   o_misalign       one-cycle pulse when a misaligned target was loaded
//   o_misalign_pc    raw offending target, held until the next such event
module pc_gen
  import pc_pkg::*;
#(
  parameter int                N_ADDR     = 32,
  parameter logic [N_ADDR-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [5:0]        i_stall,
  input  logic              i_flush,
  input  logic [N_ADDR-1:0] i_new_pc,
  input  logic              i_branch_vld,
  input  logic [N_ADDR-1:0] i_branch_addr,
  pc_gen_if.master          fetch,
  output logic              o_misalign,
  output logic [N_ADDR-1:0] o_misalign_pc
);

  localparam logic [N_ADDR-1:0] LOW_MASK = N_ADDR'(align_mask(INST_BYTES));
  localparam logic [N_ADDR-1:0] PC_STEP  = N_ADDR'(INST_BYTES);

  // ---------------------------------------------------------------------
  // FSM: S_OFF only while in reset, S_RUN from the first edge after release
  // ---------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_OFF;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_OFF:   state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_OFF;
    endcase
  end

  logic run;
  assign run = (state_reg == S_RUN);

  // ---------------------------------------------------------------------
  // Pending-branch buffer
  // ---------------------------------------------------------------------
  logic              buf_capture;
  logic              buf_clear;
  logic              buf_consume;
  logic              pend_vld;
  logic [N_ADDR-1:0] pend_addr;

  pc_redirect_buf #(
    .N_ADDR (N_ADDR)
  ) u_redirect_buf (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .capture      (buf_capture),
    .clear        (buf_clear),
    .consume      (buf_consume),
    .capture_addr (i_branch_addr),
    .pend_vld     (pend_vld),
    .pend_addr    (pend_addr)
  );

  // ---------------------------------------------------------------------
  // Next-PC priority mux, incrementer and misalign detection
  // ---------------------------------------------------------------------
  logic              adv;
  logic              stop;
  logic              branch;
  logic              load_target;
  logic [N_ADDR-1:0] target;
  logic [N_ADDR-1:0] pc_reg;
  logic [N_ADDR-1:0] pc_next;
  logic              mis_reg;
  logic              mis_next;
  logic [N_ADDR-1:0] mis_pc_reg;
  logic [N_ADDR-1:0] mis_pc_next;

  // Only one stall bit matters here; the rest of the vector belongs to
  // later pipeline stages and is deliberately ignored.
  logic unused_stall;
  assign unused_stall = ^i_stall;

  assign stop   = (i_stall[STALL_BIT] == STALL_STOP);
  assign branch = (i_branch_vld == BRANCH_TAKEN);
  // A stalled cycle with ready high still counts as "no advance": memory
  // may see the same address twice, which it tolerates.
  assign adv    = fetch.i_req_rdy & ~stop;

  always_comb begin
    pc_next     = pc_reg;
    mis_next    = 1'b0;
    mis_pc_next = mis_pc_reg;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;
    buf_consume = 1'b0;
    load_target = 1'b0;
    target      = '0;

    if (run) begin
      if (i_flush) begin
        // Also the only way o_pc may move under an unaccepted request;
        // memory treats that change as an abort.
        load_target = 1'b1;
        target      = i_new_pc;
        buf_clear   = 1'b1;
      end else if (!adv) begin
        buf_capture = branch;
      end else if (branch) begin
        load_target = 1'b1;
        target      = i_branch_addr;
        buf_clear   = 1'b1;
      end else if (pend_vld) begin
        load_target = 1'b1;
        target      = pend_addr;
        buf_consume = 1'b1;
      end else begin
        pc_next = pc_reg + PC_STEP;
      end
    end

    // Alignment is judged on whatever target is being applied now, so a
    // buffered branch is checked on its way out rather than on capture.
    if (load_target) begin
      pc_next = target & ~LOW_MASK;
      if ((target & LOW_MASK) != '0) begin
        mis_next    = 1'b1;
        mis_pc_next = target;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_reg     <= RESET_VEC;
      mis_reg    <= 1'b0;
      mis_pc_reg <= '0;
    end else begin
      pc_reg     <= pc_next;
      mis_reg    <= mis_next;
      mis_pc_reg <= mis_pc_next;
    end
  end

  // Enable and valid come straight from the state register, so every
  // output is a flop output.
  assign fetch.o_ce      = run;
  assign fetch.o_req_vld = run;
  assign fetch.o_pc      = pc_reg;
  assign o_misalign      = mis_reg;
  assign o_misalign_pc   = mis_pc_reg;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage: it supersedes the fixed 32-bit, always-fetching PC register. It drives instruction-memory requests over a valid/ready handshake and makes the reset vector, address width and instruction size configurable. Branches that arrive while fetch cannot advance are buffered rather than dropped. Misaligned redirect targets are reported. It sits between the ID/EX redirect sources, the exception controller (flush) and the instruction-memory port.

## Interface
- N_ADDR, 32, PC/address width in bits
- RESET_VEC, 'h0, first fetch address after reset (N_ADDR bits)
- INST_BYTES, 4, instruction size in bytes; power of two, ≥1
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_stall  in  6  pipeline stall vector; only bit 0 is used (1 = STOP)
- i_flush  in  1  exception flush, highest priority
- i_new_pc  in  N_ADDR  flush target
- i_branch_vld  in  1  branch/jump redirect request, single-cycle
- i_branch_addr  in  N_ADDR  redirect target
- o_ce  out  1  fetch enable
- o_req_vld  out  1  fetch request valid
- i_req_rdy  in  1  memory accepts request this cycle
- o_pc  out  N_ADDR  fetch address
- o_misalign  out  1  one-cycle pulse: a misaligned target was loaded
- o_misalign_pc  out  N_ADDR  offending target; holds until the next misalign event

## Operation
- States (enum):
  - S_OFF: during reset.
  - S_RUN: all other times.
  - S_OFF→S_RUN on the first clock after deassertion. There is no return except through reset.
- Reset values: o_ce=0, o_req_vld=0, o_pc=RESET_VEC, o_misalign=0, o_misalign_pc=0, pending buffer empty.
- o_ce = o_req_vld = (state==S_RUN).
- adv = i_req_rdy & ~i_stall[0].
- Next-PC priority, evaluated each cycle in S_RUN:
  1. i_flush: o_pc←i_new_pc. The pending buffer is cleared, and any simultaneous branch is discarded.
  2. ~adv: o_pc holds. If i_branch_vld=1, i_branch_addr is captured into the pending buffer; a newer branch overwrites an older one.
  3. adv & i_branch_vld: o_pc←i_branch_addr, and pending is cleared.
  4. adv & pending valid: o_pc←pending addr, and pending is cleared.
  5. adv: o_pc←o_pc+INST_BYTES, wrapping modulo 2^N_ADDR.
- A stall with i_req_rdy=1 re-fetches the same o_pc; this is legal and memory may repeat the fetch.
- A flush aborts an unaccepted request. Memory treats the o_pc change under o_req_vld as an abort. This is the only case where o_pc changes without acceptance.
- Misalignment: a target (flush, branch or pending) with low log2(INST_BYTES) bits nonzero is handled as follows:
  - o_pc loads the target with those bits cleared.
  - o_misalign pulses the following cycle.
  - o_misalign_pc holds the raw target.
  - Pending captures are checked when they are applied, not when they are captured.

## Timing
- All outputs are registered, and redirect latency is 1 cycle (input cycle N → o_pc at N+1).
- First request: o_req_vld=1 with o_pc=RESET_VEC in the first cycle after the first post-reset edge.
- Handshake: while o_req_vld=1 and i_req_rdy=0, o_pc is stable except on flush.
- Async reset mid-operation has the following effects:
  - It returns everything immediately to reset values.
  - A pending branch is lost.
  - The first fetch after release is again RESET_VEC.

## Structure
- Package pc_pkg holds the state enum, the stall-bit index, the STOP/BRANCH encodings, and an alignment helper function parameterised by INST_BYTES.
- Sub-module pc_redirect_buf holds the one-entry pending-branch register. Its ports are capture, clear, consume, the address, and a valid output.
- The top level holds the FSM, the priority mux, the incrementer and the misalign logic.

## Test plan
- Reset release, RESET_VEC='h0000_1000, i_req_rdy=1 → o_pc 'h1000, 'h1004, 'h1008 on consecutive cycles; o_ce=0 during reset.
- i_req_rdy=0 for 3 cycles at o_pc='h20, with a branch to 'h400 in the 2nd cycle → o_pc holds 'h20; after rdy rises, next o_pc='h400, then 'h404.
- i_stall[0]=1 with branch 'h80 and a simultaneous flush to 'h8000_0180 → o_pc='h8000_0180 and pending is empty; after the stall clears, o_pc='h8000_0184 (not 'h80).
- Branch to 'h102 with INST_BYTES=4 → o_pc='h100, o_misalign pulses 1 cycle, o_misalign_pc='h102.
- N_ADDR=16, o_pc='hFFFC, advance → o_pc='h0000.
- Assert reset while pending holds 'h400 and state is S_RUN → all outputs at reset values immediately; after release the first o_pc=RESET_VEC and the branch is not replayed.
